// File: rtl/ahb_dma_write_master_if.sv
// ---------------------------------------------------------------------------
// ahb_dma_write_master_if
// Purpose : AHB-Lite write-master bus bundle used between the DMA write master
//           and the memory model / checker.
// Signals : HTRANS, HADDR, HWRITE, HSIZE, HBURST, HWDATA  (master -> slave)
//           HREADY, HRESP                                  (slave  -> master)
// Handshake: an address phase is accepted at a rising HCLK edge where
//           HREADY=1 and HTRANS is NONSEQ or SEQ; the matching data phase
//           occupies the following cycle(s) and ends at the next edge with
//           HREADY=1. While HREADY=0 the master holds address, control and
//           write data unchanged. HRESP=1 flags an error response.
// ---------------------------------------------------------------------------
package ahb_dma_write_master_pkg;
    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } HTRANS_state;
endpackage

interface ahb_dma_write_master_if;
    import ahb_dma_write_master_pkg::*;

    HTRANS_state HTRANS;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        output HTRANS, HADDR, HWRITE, HSIZE, HBURST, HWDATA,
        input  HREADY, HRESP
    );

    modport slave (
        input  HTRANS, HADDR, HWRITE, HSIZE, HBURST, HWDATA,
        output HREADY, HRESP
    );
endinterface

// File: rtl/ahb_dma_write_master.sv
// ---------------------------------------------------------------------------
// ahb_dma_write_master
// Purpose : Runs one DMA write transfer per start request as an AHB-Lite INCR
//           burst of N single-word beats. Beat k writes init_data+k to
//           base+k*ADDR_INC (32-bit wrap on both).
// Ports   : HCLK, HRESETn         clock / async active-low reset
//           start                 one-cycle request, honoured only in IDLE
//           RCC_Words_N           beat count (0..63)
//           RCC_DMA_ADDR_HIGH/LOW base address halves
//           init_data             data seed for beat 0
//           bus                   AHB-Lite master modport
//           busy, done, error     transfer status (done/error are pulses)
//           dbg_state_o           current FSM state for observation
// All outputs are registered.
// ---------------------------------------------------------------------------
module ahb_dma_write_master
    import ahb_dma_write_master_pkg::*;
#(
    parameter logic [31:0] ADDR_INC   = 32'd1,
    parameter logic [2:0]  HSIZE_WORD = 3'b010
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic                          start,
    input  logic [5:0]                    RCC_Words_N,
    input  logic [15:0]                   RCC_DMA_ADDR_HIGH,
    input  logic [15:0]                   RCC_DMA_ADDR_LOW,
    input  logic [31:0]                   init_data,
    ahb_dma_write_master_if.master        bus,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic [2:0]                    dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_LAST = 3'd2,
        S_ERR  = 3'd3,
        S_FIN  = 3'd4
    } state_e;

    localparam logic [2:0] HBURST_INCR = 3'b001;

    state_e      state_q;
    logic [5:0]  n_q;       // latched beat count
    logic [5:0]  beat_q;    // index of the beat currently in its address phase
    logic [31:0] init_q;    // latched data seed
    logic        dphase_q;  // a data phase is outstanding on the bus

    HTRANS_state htrans_q;
    logic [31:0] haddr_q;
    logic        hwrite_q;
    logic [2:0]  hsize_q;
    logic [2:0]  hburst_q;
    logic [31:0] hwdata_q;
    logic        busy_q;
    logic        done_q;
    logic        error_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= S_IDLE;
            n_q      <= '0;
            beat_q   <= '0;
            init_q   <= '0;
            dphase_q <= 1'b0;
            htrans_q <= HTRANS_IDLE;
            haddr_q  <= '0;
            hwrite_q <= 1'b0;
            hsize_q  <= '0;
            hburst_q <= '0;
            hwdata_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        n_q      <= RCC_Words_N;
                        init_q   <= init_data;
                        beat_q   <= '0;
                        dphase_q <= 1'b0;
                        if (RCC_Words_N != 6'd0) begin
                            state_q  <= S_ADDR;
                            htrans_q <= HTRANS_NONSEQ;
                            haddr_q  <= {RCC_DMA_ADDR_HIGH, RCC_DMA_ADDR_LOW};
                            hwrite_q <= 1'b1;
                            hsize_q  <= HSIZE_WORD;
                            hburst_q <= HBURST_INCR;
                            busy_q   <= 1'b1;
                        end else begin
                            // Empty transfer: report completion, never touch the bus.
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                        end
                    end
                end

                S_ADDR: begin
                    if (dphase_q && bus.HRESP) begin
                        // Error on the outstanding data phase cancels the pending address.
                        htrans_q <= HTRANS_IDLE;
                        hwrite_q <= 1'b0;
                        hsize_q  <= '0;
                        hburst_q <= '0;
                        if (bus.HREADY) begin
                            state_q <= S_FIN;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            error_q <= 1'b1;
                        end else begin
                            state_q <= S_ERR;
                        end
                    end else if (bus.HREADY) begin
                        // Address of beat_q accepted; its data phase starts now.
                        hwdata_q <= init_q + {26'd0, beat_q};
                        dphase_q <= 1'b1;
                        if (beat_q == n_q - 6'd1) begin
                            state_q  <= S_LAST;
                            htrans_q <= HTRANS_IDLE;
                            hwrite_q <= 1'b0;
                            hsize_q  <= '0;
                            hburst_q <= '0;
                        end else begin
                            htrans_q <= HTRANS_SEQ;
                            haddr_q  <= haddr_q + ADDR_INC;
                            beat_q   <= beat_q + 6'd1;
                        end
                    end
                end

                S_LAST: begin
                    if (bus.HREADY) begin
                        state_q <= S_FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        error_q <= bus.HRESP;
                    end else if (bus.HRESP) begin
                        state_q <= S_ERR;
                    end
                end

                S_ERR: begin
                    // Second cycle of the two-cycle error response.
                    if (bus.HREADY) begin
                        state_q <= S_FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        error_q <= 1'b1;
                    end
                end

                S_FIN: begin
                    state_q  <= S_IDLE;
                    dphase_q <= 1'b0;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.HTRANS = htrans_q;
    assign bus.HADDR  = haddr_q;
    assign bus.HWRITE = hwrite_q;
    assign bus.HSIZE  = hsize_q;
    assign bus.HBURST = hburst_q;
    assign bus.HWDATA = hwdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/ahb_dma_write_master.md
Name: ahb_dma_write_master

Overview:
AHB-Lite write master that runs one DMA transfer per start request.
- Latches the RCC configuration (word count, split base address) and a data seed at start.
- Issues an INCR write burst of N single-word beats. Beat k writes init_data+k to base+k*ADDR_INC.
- Drives the bus that the memory model and the CPU-side checker observe, and reports busy, done and error to the control logic.

Parameters:
ADDR_INC, 1, address increment per accepted beat (32-bit modulo add)
HSIZE_WORD, 3'b010, HSIZE value driven during active beats

Ports:
HCLK  input  1  system clock, rising edge
HRESETn  input  1  asynchronous active-low reset
start  input  1  single-cycle request; sampled only in IDLE
RCC_Words_N  input  6  beat count N (0..63), latched at accepted start
RCC_DMA_ADDR_HIGH  input  16  base address [31:16], latched at start
RCC_DMA_ADDR_LOW  input  16  base address [15:0], latched at start
init_data  input  32  data seed for beat 0, latched at start
HREADY  input  1  slave ready; low extends the current data phase
HRESP  input  1  slave error response
HTRANS  output  HTRANS_state  IDLE/NONSEQ/SEQ (BUSY never driven)
HADDR  output  32  beat address
HWRITE  output  1  1 during active beats
HSIZE  output  3  HSIZE_WORD during active beats, else 0
HBURST  output  3  3'b001 (INCR) during active beats, else 0
HWDATA  output  32  write data, valid in data phase
busy  output  1  transfer in progress
done  output  1  one-cycle completion pulse
error  output  1  one-cycle pulse, coincident with done, when the transfer aborted on HRESP

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE; HTRANS=IDLE.
  - HADDR, HWDATA, HWRITE, HSIZE, HBURST, busy, done, error all 0.
  - Reset mid-burst abandons the transfer; no done pulse is generated.
- States:
  - IDLE: start=1 latches config; N>0 goes to ADDR, N=0 goes to FIN.
  - ADDR: address phase of beats 0..N-1. HTRANS=NONSEQ for beat 0, SEQ after.
  - LAST: HTRANS=IDLE; waits for the final data phase to complete.
  - ERR: HTRANS=IDLE; waits for HREADY=1 to finish the two-cycle error response.
  - FIN: done=1 (and error=1 if entered from ERR) for one cycle, then IDLE.
- Start timing:
  - start accepted at edge t: HTRANS=NONSEQ and HADDR=base from cycle t+1; busy=1 from t+1.
  - start is ignored while busy.
- Beat acceptance:
  - An address phase is accepted at an edge where HREADY=1 and HTRANS is NONSEQ or SEQ.
  - HTRANS, HADDR and control are held unchanged while HREADY=0.
  - After beat k is accepted: if k<N-1, next cycle drives SEQ with HADDR+ADDR_INC; if k=N-1, go to LAST.
- Data phase:
  - HWDATA=init_data+k in the cycle after beat k's address is accepted.
  - HWDATA is held while HREADY=0.
  - Data and address increments are 32-bit and wrap modulo 2^32.
- Completion:
  - In LAST, the edge with HREADY=1 ends the final data phase; next state is FIN.
  - busy deasserts in the FIN cycle, concurrent with done.
  - N=0: FIN follows start by one cycle; no bus activity; HTRANS stays IDLE.
- Error response:
  - HRESP=1 with HREADY=0 during any data phase: the next cycle drives HTRANS=IDLE (pending address cancelled), state ERR.
  - Remaining beats are not issued.
  - HRESP=1 with HREADY=1 is treated as an error end of the data phase; go to FIN with error.
- Simultaneous events: start asserted during FIN is ignored; it is accepted only when state=IDLE.
- Cycle counts, zero wait states: the bus shows NONSEQ + (N-1) SEQ cycles, then IDLE. done occurs at cycle t+N+2.

Test Plan:
- N=4, base=0x0000_1000, init=0x10, HREADY=1:
  - HTRANS NONSEQ,SEQ,SEQ,SEQ,IDLE.
  - HADDR 0x1000..0x1003; HWDATA 0x10..0x13, each one cycle later.
  - done at t+6; busy high t+1..t+5.
- N=3 with HREADY=0 for 2 cycles during beat 1's data phase:
  - HADDR=base+2 and HWDATA=init+1 held stable through the stall.
  - Data sequence unchanged; done delayed by 2 cycles.
- N=0 start: no NONSEQ issued; done=1, error=0 at t+1; busy never set.
- N=5, HRESP=1/HREADY=0 on beat 2's data phase, then HRESP=1/HREADY=1:
  - HTRANS=IDLE the following cycle; beats 3 and 4 never issued.
  - done=1 and error=1 together.
- base=0xFFFF_FFFE, init=0xFFFF_FFFF, N=3:
  - HADDR FFFF_FFFE, FFFF_FFFF, 0000_0000.
  - HWDATA FFFF_FFFF, 0, 1.
- Assert HRESETn=0 mid-burst, then start again during busy:
  - Outputs go to reset values immediately; no done pulse.
  - After release, the first start is accepted.
  - A second start issued mid-burst is ignored.
